// File: rtl/jtkiwi_palctl_pkg.sv
// Shared constants for the kiwi palette controller: default palette address
// width and the encoding of the fill engine states.
package jtkiwi_palctl_pkg;

   localparam int PAL_AW = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } pal_st_t;

endpackage

// File: rtl/jtkiwi_palctl.sv
// Palette RAM write-port controller: CPU accesses and a fill engine share one port.
// Port outputs are registered (1 clk); the CPU always wins and the fill engine stalls in place.
module jtkiwi_palctl
   import jtkiwi_palctl_pkg::*;
#(
   parameter int AW         = PAL_AW,
   parameter bit BLANK_ONLY = 1'b0
)(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          blank_i,
   input  logic          pal_cs_i,
   input  logic          cpu_rnw_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [7:0]    cpu_dout_i,
   output logic [7:0]    cpu_din_o,
   input  logic          fill_start_i,
   input  logic [AW-1:0] fill_first_i,
   input  logic [AW-1:0] fill_last_i,
   input  logic [7:0]    fill_val_i,
   input  logic          fill_inc_i,
   output logic          fill_busy_o,
   output logic          fill_done_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [7:0]    ram_din_o,
   output logic          ram_we_o,
   input  logic [7:0]    ram_q_i
);

   pal_st_t       state_q;
   logic [AW-1:0] cnt_addr_q, end_addr_q;
   logic [7:0]    cnt_data_q;
   logic          inc_q, busy_q, done_q;

   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]    ram_din_q, ram_din_d;
   logic          ram_we_q, ram_we_d;
   logic          eng_ok;

   // The engine only gets the port on cycles the CPU leaves free.
   assign eng_ok = (state_q == ST_FILL) && !pal_cs_i && (!BLANK_ONLY || blank_i);

   always_comb begin
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      ram_we_d   = 1'b0;
      if (pal_cs_i) begin
         ram_addr_d = cpu_addr_i;
         ram_din_d  = cpu_dout_i;
         ram_we_d   = !cpu_rnw_i;
      end else if (eng_ok) begin
         ram_addr_d = cnt_addr_q;
         ram_din_d  = cnt_data_q;
         ram_we_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         ram_we_q   <= 1'b0;
      end else begin
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         ram_we_q   <= ram_we_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_addr_q <= '0;
         end_addr_q <= '0;
         cnt_data_q <= '0;
         inc_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fill_start_i) begin
                  state_q    <= ST_FILL;
                  busy_q     <= 1'b1;
                  cnt_addr_q <= fill_first_i;
                  end_addr_q <= fill_last_i;
                  cnt_data_q <= fill_val_i;
                  inc_q      <= fill_inc_i;
               end
            end
            ST_FILL: begin
               if (eng_ok) begin
                  cnt_addr_q <= cnt_addr_q + AW'(1);
                  cnt_data_q <= cnt_data_q + {7'd0, inc_q};
                  // Equality test (not <=) so ranges wrapping through the top work.
                  if (cnt_addr_q == end_addr_q) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ram_addr_o  = ram_addr_q;
   assign ram_din_o   = ram_din_q;
   assign ram_we_o    = ram_we_q;
   assign fill_busy_o = busy_q;
   assign fill_done_o = done_q;
   assign cpu_din_o   = ram_q_i;

endmodule

// File: tb/tb_jtkiwi_palctl.sv
// Bench for jtkiwi_palctl: one instance per BLANK_ONLY setting, checked every cycle
// against a queue-based model of the fill range, plus directed scenario checks.
module tb_jtkiwi_palctl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       blank = 1'b1;
   logic       pal_cs = 1'b0, cpu_rnw = 1'b1;
   logic [9:0] cpu_addr = '0;
   logic [7:0] cpu_dout = '0;
   logic       fill_start = 1'b0, fill_inc = 1'b0;
   logic [9:0] fill_first = '0, fill_last = '0;
   logic [7:0] fill_val = '0;

   logic [7:0] cpu_din0, cpu_din1, ram_din0, ram_din1, ram_q0, ram_q1;
   logic [9:0] ram_addr0, ram_addr1;
   logic       busy0, busy1, done0, done1, we0, we1;

   logic [7:0] mem0 [1024];
   logic [7:0] mem1 [1024];

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   jtkiwi_palctl #(.AW(10), .BLANK_ONLY(1'b0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .blank_i(blank), .pal_cs_i(pal_cs), .cpu_rnw_i(cpu_rnw),
      .cpu_addr_i(cpu_addr), .cpu_dout_i(cpu_dout), .cpu_din_o(cpu_din0),
      .fill_start_i(fill_start), .fill_first_i(fill_first), .fill_last_i(fill_last),
      .fill_val_i(fill_val), .fill_inc_i(fill_inc), .fill_busy_o(busy0), .fill_done_o(done0),
      .ram_addr_o(ram_addr0), .ram_din_o(ram_din0), .ram_we_o(we0), .ram_q_i(ram_q0));

   jtkiwi_palctl #(.AW(10), .BLANK_ONLY(1'b1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .blank_i(blank), .pal_cs_i(pal_cs), .cpu_rnw_i(cpu_rnw),
      .cpu_addr_i(cpu_addr), .cpu_dout_i(cpu_dout), .cpu_din_o(cpu_din1),
      .fill_start_i(fill_start), .fill_first_i(fill_first), .fill_last_i(fill_last),
      .fill_val_i(fill_val), .fill_inc_i(fill_inc), .fill_busy_o(busy1), .fill_done_o(done1),
      .ram_addr_o(ram_addr1), .ram_din_o(ram_din1), .ram_we_o(we1), .ram_q_i(ram_q1));

   // Palette RAM stand-ins: synchronous write, 1-clk registered read.
   always @(posedge clk) begin
      ram_q0 <= mem0[ram_addr0];
      ram_q1 <= mem1[ram_addr1];
      if (we0) mem0[ram_addr0] <= ram_din0;
      if (we1) mem1[ram_addr1] <= ram_din1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: a fill is expanded up-front into the list of (addr,data)
   // entries it must write; the engine pops one entry per free cycle.
   localparam int M_IDLE = 0, M_FILL = 1, M_DONE = 2;
   int         m_st [2];
   logic       e_we [2], e_busy [2], e_done [2];
   logic [9:0] e_addr [2];
   logic [7:0] e_din [2], e_q [2];
   logic [7:0] mm [2][1024];
   logic [17:0] fq0 [$];
   logic [17:0] fq1 [$];

   task automatic model_step(input int i);
      logic [17:0] ent;
      logic        elig, take;
      int          n, left;
      e_q[i] = mm[i][e_addr[i]];
      if (e_we[i]) mm[i][e_addr[i]] = e_din[i];
      if (rst) begin
         m_st[i] = M_IDLE; e_we[i] = 1'b0; e_addr[i] = '0; e_din[i] = '0;
         e_busy[i] = 1'b0; e_done[i] = 1'b0;
         if (i == 0) fq0.delete(); else fq1.delete();
         return;
      end
      elig = (i == 0) || blank;
      take = (m_st[i] == M_IDLE) && fill_start;
      e_done[i] = 1'b0;
      if (pal_cs) begin
         e_we[i] = !cpu_rnw; e_addr[i] = cpu_addr; e_din[i] = cpu_dout;
      end else if (m_st[i] == M_FILL && elig) begin
         if (i == 0) begin ent = fq0.pop_front(); left = fq0.size(); end
         else begin ent = fq1.pop_front(); left = fq1.size(); end
         e_we[i] = 1'b1; e_addr[i] = ent[17:8]; e_din[i] = ent[7:0];
         if (left == 0) begin m_st[i] = M_DONE; e_done[i] = 1'b1; end
      end else begin
         e_we[i] = 1'b0;
      end
      if (m_st[i] == M_DONE && !e_done[i]) m_st[i] = M_IDLE;
      if (take) begin
         n = ((int'(fill_last) - int'(fill_first)) & 1023) + 1;
         for (int k = 0; k < n; k++) begin
            ent = {10'(int'(fill_first) + k), 8'(int'(fill_val) + (fill_inc ? k : 0))};
            if (i == 0) fq0.push_back(ent); else fq1.push_back(ent);
         end
         m_st[i] = M_FILL;
      end
      e_busy[i] = (m_st[i] == M_FILL);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_st[i] = M_IDLE; e_we[i] = 1'b0; e_addr[i] = '0; e_din[i] = '0;
         e_busy[i] = 1'b0; e_done[i] = 1'b0; e_q[i] = '0;
         for (int a = 0; a < 1024; a++) mm[i][a] = '0;
      end
      for (int a = 0; a < 1024; a++) begin mem0[a] = '0; mem1[a] = '0; end
      forever begin
         @(posedge clk);
         model_step(0);
         model_step(1);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("d0_we",   {31'd0, we0},   {31'd0, e_we[0]});
            check("d0_addr", {22'd0, ram_addr0}, {22'd0, e_addr[0]});
            check("d0_din",  {24'd0, ram_din0},  {24'd0, e_din[0]});
            check("d0_busy", {31'd0, busy0}, {31'd0, e_busy[0]});
            check("d0_done", {31'd0, done0}, {31'd0, e_done[0]});
            check("d0_cpu_din", {24'd0, cpu_din0}, {24'd0, e_q[0]});
            check("d1_we",   {31'd0, we1},   {31'd0, e_we[1]});
            check("d1_addr", {22'd0, ram_addr1}, {22'd0, e_addr[1]});
            check("d1_din",  {24'd0, ram_din1},  {24'd0, e_din[1]});
            check("d1_busy", {31'd0, busy1}, {31'd0, e_busy[1]});
            check("d1_done", {31'd0, done1}, {31'd0, e_done[1]});
            check("d1_cpu_din", {24'd0, cpu_din1}, {24'd0, e_q[1]});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_fill(input logic [9:0] f, input logic [9:0] l, input logic [7:0] v, input logic inc);
      fill_first = f; fill_last = l; fill_val = v; fill_inc = inc; fill_start = 1'b1;
      cyc();
      fill_start = 1'b0;
   endtask

   int cnt0 [1024];
   int cnt1 [1024];

   initial begin
      int nbusy, done_at, nw, bad, nbad0, nbad1, blank_bad, hold;
      bit fin0, fin1;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_we", {31'd0, we0}, 32'd0);
      check("rst_addr", {22'd0, ram_addr0}, 32'd0);
      check("rst_busy", {31'd0, busy1}, 32'd0);

      // CPU write then read-back with 2-clk latency
      pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 10'h155; cpu_dout = 8'hA5;
      cyc();
      pal_cs = 1'b0; cpu_rnw = 1'b1;
      check("cpu_wr_we", {31'd0, we0}, 32'd1);
      check("cpu_wr_addr", {22'd0, ram_addr0}, 32'h155);
      check("cpu_wr_din", {24'd0, ram_din0}, 32'hA5);
      pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 10'h155;
      cyc();
      pal_cs = 1'b0;
      cyc();
      check("cpu_rd_data", {24'd0, cpu_din0}, 32'hA5);

      // Incrementing fill 0x010..0x013
      blank = 1'b1;
      start_fill(10'h010, 10'h013, 8'h80, 1'b1);
      nbusy = 0; done_at = -1; nw = 0;
      for (int k = 0; k < 8; k++) begin
         if (busy0) nbusy++;
         if (done0) done_at = k;
         if (we0) begin
            check("fill_addr", {22'd0, ram_addr0}, 32'h010 + 32'(nw));
            check("fill_data", {24'd0, ram_din0}, 32'h80 + 32'(nw));
            if (nw == 0) check("fill_first_clk", 32'(k), 32'd1);
            nw++;
         end
         cyc();
      end
      check("fill_nwrites", 32'(nw), 32'd4);
      check("fill_busy_clks", 32'(nbusy), 32'd4);
      check("fill_done_at", 32'(done_at), 32'd4);

      // Wrapping constant fill 1022..1
      start_fill(10'd1022, 10'd1, 8'h00, 1'b0);
      nw = 0; bad = 0;
      for (int k = 0; k < 7; k++) begin
         if (we0) begin
            if (ram_addr0 == 10'd2 || ram_addr0 == 10'd1021 || ram_din0 != 8'h00) bad++;
            if (nw == 0) check("wrap_first", {22'd0, ram_addr0}, 32'd1022);
            nw++;
         end
         cyc();
      end
      check("wrap_nwrites", 32'(nw), 32'd4);
      check("wrap_bad", 32'(bad), 32'd0);

      // CPU steals the 2nd engine cycle; a second start mid-fill is ignored
      start_fill(10'h010, 10'h013, 8'h80, 1'b1);
      cyc();
      pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 10'h200; cpu_dout = 8'h5A;
      cyc();
      pal_cs = 1'b0; cpu_rnw = 1'b1;
      check("ilv_cpu_addr", {22'd0, ram_addr0}, 32'h200);
      check("ilv_cpu_din", {24'd0, ram_din0}, 32'h5A);
      fill_first = 10'h300; fill_last = 10'h3FF; fill_val = 8'h11; fill_start = 1'b1;
      cyc();
      fill_start = 1'b0;
      check("ilv_resume_addr", {22'd0, ram_addr0}, 32'h011);
      check("ilv_resume_din", {24'd0, ram_din0}, 32'h81);
      cyc();
      check("ilv_no_early_done", {31'd0, done0}, 32'd0);
      cyc();
      check("ilv_late_done", {31'd0, done0}, 32'd1);
      cyc();
      check("ilv_ignored_start", {31'd0, busy0}, 32'd0);

      // Reset mid-fill aborts without a done pulse
      start_fill(10'd0, 10'd200, 8'h33, 1'b1);
      repeat (5) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_we", {31'd0, we0}, 32'd0);
      check("abort_done", {31'd0, done0}, 32'd0);
      repeat (3) cyc();

      // Randomised traffic against the model
      for (int c = 0; c < 3000; c++) begin
         pal_cs = ($urandom_range(0, 3) == 0);
         cpu_rnw = $urandom_range(0, 1);
         cpu_addr = 10'($urandom);
         cpu_dout = 8'($urandom);
         blank = ($urandom_range(0, 2) != 0);
         fill_start = ($urandom_range(0, 19) == 0);
         fill_first = 10'($urandom);
         fill_last = 10'(int'(fill_first) + $urandom_range(0, 40));
         fill_val = 8'($urandom);
         fill_inc = $urandom_range(0, 1);
         rst = ($urandom_range(0, 299) == 0);
         cyc();
      end
      pal_cs = 1'b0; fill_start = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;

      // Full 1024-entry fill with blank toggling
      for (int a = 0; a < 1024; a++) begin cnt0[a] = 0; cnt1[a] = 0; end
      blank = 1'b0;
      start_fill(10'd0, 10'd1023, 8'($urandom), 1'b1);
      fin0 = 1'b0; fin1 = 1'b0; blank_bad = 0; hold = 0;
      for (int c = 0; c < 6000 && !(fin0 && fin1); c++) begin
         if (hold == 0) begin blank = ~blank; hold = $urandom_range(1, 20); end
         hold--;
         cyc();
         if (we0) cnt0[ram_addr0]++;
         if (we1) begin cnt1[ram_addr1]++; if (!blank) blank_bad++; end
         if (done0) fin0 = 1'b1;
         if (done1) fin1 = 1'b1;
      end
      check("full_done0", {31'd0, fin0}, 32'd1);
      check("full_done1", {31'd0, fin1}, 32'd1);
      nbad0 = 0; nbad1 = 0;
      for (int a = 0; a < 1024; a++) begin
         if (cnt0[a] != 1) nbad0++;
         if (cnt1[a] != 1) nbad1++;
      end
      check("full_once0", 32'(nbad0), 32'd0);
      check("full_once1", 32'(nbad1), 32'd0);
      check("full_blank_gate", 32'(blank_bad), 32'd0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
